fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the core. Acts as the Wishbone master in front of the instruction ROM. It maintains the fetch PC, issues one word read at a time, and buffers returned words with their PCs in a small FIFO. Decode drains that FIFO through a valid/ready handshake, and branch/jump redirects from execute flush the buffer.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
- FIFO_DEPTH, 2, entries in the instruction buffer (power of two, 2..8)

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- wishbone  wishbone_if.master  —  drives cycle, strobe, address[31:0]; samples ack, data_out[31:0] (slave read data)
- redirect_valid  input  1  one-cycle pulse: flush and restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
- instr_valid  output  1  FIFO head valid
- instr_ready  input  1  decode accepts head this cycle
- instr_data  output  32  instruction word at head
- instr_pc  output  32  byte address of instr_data
- perf_fetched  output  32  instructions handed to decode (see Configuration)
- perf_discarded  output  16  bus responses dropped due to redirect (see Configuration)

## Operation
- Registers: fetch_pc, FIFO storage of {pc, instr}, count (0..FIFO_DEPTH), state.
- Only one bus request is outstanding at a time. wishbone.address is fetch_pc.
- The FSM has three states:
  - IDLE: cycle=strobe=0. Go to REQ when count < FIFO_DEPTH and no redirect this cycle.
  - REQ: cycle=strobe=1, address held stable. On ack: push {fetch_pc, data_out} and set fetch_pc += 4. Then stay in REQ if count after push/pop < FIFO_DEPTH, else go to IDLE.
  - DISCARD: cycle=strobe=1, holds the old address and waits for ack. On ack: drop the data, increment perf_discarded, go to IDLE.
- Bus requests are never abandoned before ack, because the ROM completes every accepted request.
- Redirect (redirect_valid=1) has priority over everything:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO flushed (count <= 0); a same-cycle pop is ignored.
  - In IDLE, or in REQ with ack in the same cycle: ack data is dropped, next state is IDLE.
  - In REQ without ack: next state is DISCARD.
  - In DISCARD: the target is updated and the FSM stays in DISCARD.
- Pop when instr_valid && instr_ready. Push and pop in the same cycle leave count unchanged.
- count never exceeds FIFO_DEPTH, because a request is only issued when count < FIFO_DEPTH.
- fetch_pc wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).

## Timing
- Reset values:
  - cycle=0, strobe=0, address=RESET_PC.
  - instr_valid=0, instr_data=0, instr_pc=0, count=0, state=IDLE.
  - perf counters=0.
- A reset asserted mid-transaction drops the request next edge, with no wait for ack. The ROM resets on the same reset.
- The master registers strobe. A request is visible one cycle after the FSM enters REQ.
- ack is sampled for exactly one cycle. The address for the next request changes on the edge that samples ack.
- With the ROM (ack asserted two edges after strobe is first sampled):
  - First instr_valid goes high 4 edges after the first edge with reset low.
  - Steady-state throughput is one word per 3 cycles.
- The unit must not depend on fixed slave latency; any ack delay of 1 or more cycles is legal.
- instr_data and instr_pc are the combinational FIFO head. They are stable while instr_valid=1 and instr_ready=0.
- After a redirect, instr_valid is 0 on the next cycle. The first word from the new PC follows the normal latency, plus the remaining DISCARD time if applicable.

## Configuration
- FETCH_PERF_EN defined:
  - perf_fetched increments on every pop and wraps.
  - perf_discarded increments on every dropped ack, including an ack dropped in REQ by a simultaneous redirect, and saturates at 16'hFFFF.
- FETCH_PERF_EN undefined:
  - The counters are not built; both outputs are tied to 0.
  - Fetch behaviour is otherwise identical.

## Test plan
- Reset release with ROM words 0x00000013, 0x00100093, 0x00200113 at 0,4,8 and instr_ready=1 -> instr_pc sequence 0,4,8 with matching instr_data; first valid 4 edges after reset low; one word per 3 cycles.
- instr_ready=0 for 20 cycles -> count reaches FIFO_DEPTH=2, strobe drops to 0, head stays pc=0/0x00000013; on ready=1 fetch resumes at pc=8 with no lost or duplicated word.
- Redirect to 0x0000_0103 while in REQ without ack -> FSM enters DISCARD, stale ack dropped (perf_discarded=1), next delivered instr_pc=0x100, no earlier-PC word reaches decode.
- Redirect coinciding with ack and pop in the same cycle -> ack dropped, FIFO empty next cycle, instr_valid=0, next fetch address 0x100, strobe deasserted for one cycle.
- Redirect to 0xFFFF_FFFC with a slave model returning 0xDEADBEEF -> instr_pc 0xFFFFFFFC then 0x00000000 (wrap).
- Reset asserted mid-REQ -> cycle/strobe 0 on next edge, instr_valid 0, address=RESET_PC, perf counters 0; with FETCH_PERF_EN undefined both perf outputs remain 0 throughout.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - Wishbone classic read bus between the fetch master and the instruction ROM.
interface wishbone_if;
    logic        cycle;
    logic        strobe;
    logic [31:0] address;
    logic        ack;
    logic [31:0] data_out;

    modport master (output cycle, output strobe, output address, input ack, input data_out);
    modport slave  (input cycle, input strobe, input address, output ack, output data_out);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch: Wishbone read master, PC/instruction FIFO, redirect flush.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    wishbone_if.master  wishbone,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic [31:0] perf_fetched,
    output logic [15:0] perf_discarded
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t        state, state_next;
    logic          bus_active;
    logic [31:0]   bus_addr;
    logic [31:0]   fetch_pc, fetch_pc_next, redirect_target;
    logic [CW-1:0] count, count_next, count_push;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          push, pop, drop;
    logic [31:0]   mem_pc   [FIFO_DEPTH];
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    assign wishbone.cycle   = bus_active;
    assign wishbone.strobe  = bus_active;
    assign wishbone.address = bus_addr;

    assign instr_valid = (count != '0);
    assign instr_data  = instr_valid ? mem_data[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? mem_pc[rd_ptr]   : 32'h0;

    assign pop        = instr_valid && instr_ready && !redirect_valid;
    assign count_push = count + CW'(1) - CW'(pop);

    always_comb begin
        state_next = state;
        push       = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect_valid && count < DEPTH_C)
                    state_next = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    drop       = wishbone.ack;
                    state_next = wishbone.ack ? IDLE : DISCARD;
                end else if (wishbone.ack) begin
                    push       = 1'b1;
                    state_next = (count_push < DEPTH_C) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                // The stale response is consumed even if another redirect lands on it.
                if (wishbone.ack) begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect_valid)
            fetch_pc_next = redirect_target;
        else if (push)
            fetch_pc_next = fetch_pc + 32'd4;
        else
            fetch_pc_next = fetch_pc;

        if (redirect_valid)
            count_next = '0;
        else
            count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bus_active <= 1'b0;
            bus_addr   <= RESET_PC;
            fetch_pc   <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            state      <= state_next;
            bus_active <= (state_next != IDLE);
            fetch_pc   <= fetch_pc_next;
            count      <= count_next;
            // An accepted request keeps its address until the slave acknowledges it.
            if (!(state != IDLE && !wishbone.ack))
                bus_addr <= fetch_pc_next;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= fetch_pc;
            mem_data[wr_ptr] <= wishbone.data_out;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [15:0] discarded_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q   <= '0;
            discarded_q <= '0;
        end else begin
            if (pop)
                fetched_q <= fetched_q + 32'd1;
            if (drop && discarded_q != 16'hFFFF)
                discarded_q <= discarded_q + 16'd1;
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_discarded = discarded_q;
`else
    assign perf_fetched   = 32'h0;
    assign perf_discarded = 16'h0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Self-checking bench for fetch_unit with a variable-latency ROM and a pop scoreboard.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] perf_fetched;
    logic [15:0] perf_discarded;

    wishbone_if wb ();

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .wishbone       (wb),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int rom_lat  = 1;
    int rom_cnt  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h0000_0013;
            32'h4: return 32'h0010_0093;
            32'h8: return 32'h0020_0113;
            default: return (a >= 32'hFFFF_0000) ? 32'hDEAD_BEEF : {a[15:0], 16'hC0DE};
        endcase
    endfunction

    // ROM: ack is registered and appears rom_lat+1 edges after strobe is first sampled.
    always @(posedge clk) begin
        if (reset) begin
            wb.ack      <= 1'b0;
            wb.data_out <= 32'h0;
            rom_cnt     <= 0;
        end else if (wb.ack) begin
            wb.ack  <= 1'b0;
            rom_cnt <= 0;
        end else if (wb.cycle && wb.strobe) begin
            if (rom_cnt >= rom_lat) begin
                wb.ack      <= 1'b1;
                wb.data_out <= rom_word(wb.address);
            end else begin
                rom_cnt <= rom_cnt + 1;
            end
        end
    end

    // Scoreboard: every accepted word must match the oldest expected {pc, data}.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready && !redirect_valid) begin
            n_pops   = n_pops + 1;
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_pop: got pc=%h data=%h, required no word", instr_pc, instr_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({instr_pc, instr_data} !== exp_e) begin
                    n_fail = n_fail + 1;
                    $display("FAIL pop_word: got pc=%h data=%h, required pc=%h data=%h",
                             instr_pc, instr_data, exp_e[63:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = pc + 32'(4 * i);
            exp_q.push_back({p, rom_word(p)});
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        instr_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        rom_lat        = 1;
        exp_q.delete();
        tick();
        tick();
        chk("rst_bus", {wb.cycle, wb.strobe, wb.address}, {2'b00, RESET_PC});
        chk("rst_head", {instr_valid, instr_pc, instr_data}, 65'h0);
        chk("rst_perf", {perf_fetched, perf_discarded}, 48'h0);
        n_pops = 0;
        reset  = 1'b0;
    endtask

    typedef struct {
        logic [31:0] target;
        int          lat;
        int          nwords;
        logic [31:0] first_pc;
    } redirect_vec_t;

    redirect_vec_t vecs[5];
    logic [11:0]   vmask;
    int            k;

    initial begin
        vecs[0] = '{32'h0000_0103, 1, 3, 32'h0000_0100};
        vecs[1] = '{32'hFFFF_FFFC, 1, 4, 32'hFFFF_FFFC};
        vecs[2] = '{32'h0000_0046, 0, 3, 32'h0000_0044};
        vecs[3] = '{32'h0000_0200, 3, 2, 32'h0000_0200};
        vecs[4] = '{32'hFFFF_FFFB, 2, 3, 32'hFFFF_FFF8};

        // Reset release: first valid on edge 4, then one word every 3 edges.
        do_reset();
        instr_ready = 1'b1;
        push_exp(32'h0, 3);
        vmask = '0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            vmask[e] = instr_valid;
        end
        chk("valid_edges", vmask, 12'h490);
        chk("stream_0_4_8_left", 64'(exp_q.size()), 64'd0);
        instr_ready = 1'b0;
        chk("perf_fetched_3", perf_fetched, PERF ? 32'd3 : 32'd0);

        // Backpressure: FIFO fills, bus goes idle, head is held.
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        chk("bp_bus_idle", {wb.cycle, wb.strobe, wb.address}, {2'b00, 32'h8});
        chk("bp_head", {instr_valid, instr_pc, instr_data}, {1'b1, 32'h0, 32'h0000_0013});
        push_exp(32'h0, 4);
        instr_ready = 1'b1;
        wait_drain("bp_resume", 40);

        // Redirect while a request is outstanding without ack: stale ack is discarded.
        do_reset();
        tick();
        tick();
        redirect_pc    = 32'h0000_0103;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("disc_hold_addr", {wb.cycle, wb.strobe, wb.address}, {2'b11, 32'h0});
        chk("disc_no_valid", instr_valid, 1'b0);
        tick();
        chk("disc_idle", {wb.cycle, wb.address}, {1'b0, 32'h100});
        chk("disc_perf", perf_discarded, PERF ? 16'd1 : 16'd0);
        push_exp(32'h100, 2);
        instr_ready = 1'b1;
        wait_drain("disc_resume", 40);

        // Redirect landing on the same edge as an ack and a pop.
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        chk("ackpop_pre", {instr_valid, wb.ack}, 2'b11);
        redirect_pc    = 32'h0000_0100;
        redirect_valid = 1'b1;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        chk("ackpop_flush", {instr_valid, wb.cycle, wb.strobe, wb.address}, {3'b000, 32'h100});
        chk("ackpop_perf", {perf_discarded, perf_fetched}, PERF ? {16'd1, 32'd0} : 48'd0);
        tick();
        chk("ackpop_restart", wb.strobe, 1'b1);
        push_exp(32'h100, 3);
        instr_ready = 1'b1;
        wait_drain("ackpop_resume", 40);

        // Table of redirects from varying phases and slave latencies, including PC wrap.
        for (int v = 0; v < 5; v++) begin
            rom_lat = vecs[v].lat;
            for (int i = 0; i < 2 + v; i++) tick();
            redirect_pc    = vecs[v].target;
            redirect_valid = 1'b1;
            tick();
            redirect_valid = 1'b0;
            chk($sformatf("vec%0d_flush", v), instr_valid, 1'b0);
            push_exp(vecs[v].first_pc, vecs[v].nwords);
            instr_ready = 1'b1;
            wait_drain($sformatf("vec%0d", v), 100);
        end
        chk("perf_fetched_total", perf_fetched, PERF ? 32'(n_pops) : 32'd0);

        // Reset in the middle of a request.
        rom_lat        = 1;
        redirect_pc    = 32'h0000_0300;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        k = 0;
        while (wb.cycle !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("midreq_strobe_seen", wb.strobe, 1'b1);
        reset = 1'b1;
        tick();
        chk("midreq_bus", {wb.cycle, wb.strobe, wb.address}, {2'b00, RESET_PC});
        chk("midreq_state", {instr_valid, perf_fetched, perf_discarded}, 49'h0);
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end
endmodule
